seq_decoder_2to4: RTL and testbench

SEQ_DECODER_2TO4 -- requirements
Module: seq_decoder_2to4

---
 rtl/seq_decoder_2to4_if.sv | 25 ++
 rtl/seq_decoder_2to4.sv | 101 ++++++++++
 tb/tb_seq_decoder_2to4.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/seq_decoder_2to4_if.sv
// Purpose : bundles the encoded-index input and decoded/status outputs of seq_decoder_2to4.
// Latency : n/a (signal bundle only).
// Backpressure: ready is driven by the slave; codes offered while ready=0 are dropped.
interface seq_decoder_2to4_if;
    logic [1:0] y;
    logic       v;
    logic       ready;
    logic [3:0] d;
    logic       busy;
    logic       done;
    logic [7:0] cnt;
    logic       lost;

    // Upstream encoder side: offers codes, observes decoder status.
    modport master (
        output y, v,
        input  ready, d, busy, done, cnt, lost
    );

    // Decoder side.
    modport slave (
        input  y, v,
        output ready, d, busy, done, cnt, lost
    );
endinterface

// File: rtl/seq_decoder_2to4.sv
// Purpose : 2-to-4 one-hot decoder that holds each decode for HOLD cycles then idles GAP cycles.
// Latency : d updates on the edge that accepts v (one cycle from v to d).
// Backpressure: ready only in IDLE; v while not ready is dropped and latches the sticky lost flag.
module seq_decoder_2to4 #(
    parameter int HOLD = 4,   // 1..255
    parameter int GAP  = 1    // 0..15
) (
    input  logic               clk,
    input  logic               rst,
    seq_decoder_2to4_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACTIVE = 2'd1,
        S_GAP    = 2'd2
    } state_t;

    // Counters count down to zero, so they load "length minus one".
    localparam logic [7:0] HOLD_LOAD = 8'(HOLD - 1);
    localparam logic [3:0] GAP_LOAD  = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

    state_t     state;
    logic [7:0] hold_cnt;
    logic [3:0] gap_cnt;
    logic [3:0] d_q;
    logic       done_q;
    logic [7:0] cnt_q;
    logic       lost_q;

    // Status derived straight from state so ready reacts in the same cycle.
    assign bus.ready = (state == S_IDLE);
    assign bus.busy  = (state != S_IDLE);
    assign bus.d     = d_q;
    assign bus.done  = done_q;
    assign bus.cnt   = cnt_q;
    assign bus.lost  = lost_q;

    // Decode FSM: accept in IDLE, hold d for HOLD cycles, then force GAP zero cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            hold_cnt <= 8'd0;
            gap_cnt  <= 4'd0;
            d_q      <= 4'b0000;
            done_q   <= 1'b0;
            cnt_q    <= 8'd0;
            lost_q   <= 1'b0;
        end else begin
            // Codes arriving while busy are not queued; just remember that one was lost.
            if (bus.v && (state != S_IDLE)) begin
                lost_q <= 1'b1;
            end

            case (state)
                S_IDLE: begin
                    if (bus.v) begin
                        state    <= S_ACTIVE;
                        d_q      <= 4'b0001 << bus.y;
                        hold_cnt <= HOLD_LOAD;
                        // HOLD=1: the first ACTIVE cycle is also the last one.
                        done_q   <= (HOLD_LOAD == 8'd0);
                        if (cnt_q != 8'hFF) begin
                            cnt_q <= cnt_q + 8'd1;
                        end
                    end
                end

                S_ACTIVE: begin
                    if (hold_cnt == 8'd0) begin
                        d_q    <= 4'b0000;
                        done_q <= 1'b0;
                        if (GAP > 0) begin
                            state   <= S_GAP;
                            gap_cnt <= GAP_LOAD;
                        end else begin
                            state <= S_IDLE;
                        end
                    end else begin
                        hold_cnt <= hold_cnt - 8'd1;
                        // done is registered, so raise it one cycle ahead of the count reaching zero.
                        done_q   <= (hold_cnt == 8'd1);
                    end
                end

                S_GAP: begin
                    if (gap_cnt == 4'd0) begin
                        state <= S_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt - 4'd1;
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_decoder_2to4.sv
// Purpose : checks two seq_decoder_2to4 configurations (HOLD=4/GAP=1 and HOLD=1/GAP=0) against a timing model.
// Latency : model expects d one cycle after accept, held HOLD cycles, then GAP zero cycles.
// Backpressure: model drops v while busy and tracks the sticky lost flag.
module tb_seq_decoder_2to4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       v_s = 1'b0;
    logic [1:0] y_s = 2'b00;

    always #5 clk = ~clk;

    seq_decoder_2to4_if ifa ();
    seq_decoder_2to4_if ifb ();

    assign ifa.y = y_s;
    assign ifa.v = v_s;
    assign ifb.y = y_s;
    assign ifb.v = v_s;

    seq_decoder_2to4 #(.HOLD(4), .GAP(1)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
    seq_decoder_2to4 #(.HOLD(1), .GAP(0)) dut_b (.clk(clk), .rst(rst), .bus(ifb));

    // Reference model: each DUT is described only by when its last accept happened.
    int         hold_c  [2];
    int         gap_c   [2];
    int         last_acc[2];
    logic [1:0] idx_m   [2];
    int         cnt_m   [2];
    bit         lost_m  [2];
    int         cyc;
    bit         chk_en;
    int         n_checks;
    int         n_fail;

    function automatic int age(input int i);
        return cyc - last_acc[i];
    endfunction

    function automatic bit m_active(input int i);
        return (age(i) >= 1) && (age(i) <= hold_c[i]);
    endfunction

    function automatic bit m_busy(input int i);
        return (age(i) >= 1) && (age(i) <= hold_c[i] + gap_c[i]);
    endfunction

    task automatic chk(input string tag, input int i, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s dut%0d cyc=%0d observed=%0h expected=%0h", tag, i, cyc, obs, exp);
        end
    endtask

    task automatic check_dut(input int i, input logic [3:0] d, input logic done, input logic busy,
                             input logic ready, input logic [7:0] cnt, input logic lost);
        logic [3:0] d_exp;
        d_exp = m_active(i) ? (4'(1) << idx_m[i]) : 4'b0000;
        chk("d",     i, {4'b0, d},     {4'b0, d_exp});
        chk("done",  i, {7'b0, done},  {7'b0, (m_active(i) && (age(i) == hold_c[i]))});
        chk("busy",  i, {7'b0, busy},  {7'b0, m_busy(i)});
        chk("ready", i, {7'b0, ready}, {7'b0, !m_busy(i)});
        chk("cnt",   i, cnt,           8'(cnt_m[i]));
        chk("lost",  i, {7'b0, lost},  {7'b0, lost_m[i]});
    endtask

    // One clock cycle: check outputs of the current cycle, drive inputs, advance the model.
    task automatic step(input bit r, input bit vv, input logic [1:0] yy);
        @(negedge clk);
        if (chk_en) begin
            check_dut(0, ifa.d, ifa.done, ifa.busy, ifa.ready, ifa.cnt, ifa.lost);
            check_dut(1, ifb.d, ifb.done, ifb.busy, ifb.ready, ifb.cnt, ifb.lost);
        end
        rst = r;
        v_s = vv;
        y_s = yy;
        for (int i = 0; i < 2; i++) begin
            if (r) begin
                last_acc[i] = -100000;
                cnt_m[i]    = 0;
                lost_m[i]   = 1'b0;
            end else if (vv) begin
                if (!m_busy(i)) begin
                    last_acc[i] = cyc;
                    idx_m[i]    = yy;
                    if (cnt_m[i] < 255) cnt_m[i]++;
                end else begin
                    lost_m[i] = 1'b1;
                end
            end
        end
        cyc++;
        if (r) chk_en = 1'b1;
    endtask

    initial begin
        hold_c   = '{4, 1};
        gap_c    = '{1, 0};
        last_acc = '{-100000, -100000};
        idx_m    = '{2'b00, 2'b00};
        cnt_m    = '{0, 0};
        lost_m   = '{1'b0, 1'b0};
        cyc      = 0;
        chk_en   = 1'b0;
        n_checks = 0;
        n_fail   = 0;

        // Reset, with v high during reset (must be neither accepted nor flagged lost).
        step(1, 0, 2'b00);
        step(1, 1, 2'b10);
        step(0, 0, 2'b00);

        // Single decode of y=2 with defaults: hold 4, done on the 4th, one gap cycle.
        step(0, 1, 2'b10);
        for (int k = 0; k < 8; k++) step(0, 0, 2'b00);
        chk("single_cnt", 0, ifa.cnt, 8'd1);

        // Sweep y=0..3, pulsing v only when the default-config DUT is ready.
        for (int y = 0; y < 4; y++) begin
            for (int k = 0; k < 20 && m_busy(0); k++) step(0, 0, 2'b00);
            step(0, 1, 2'(y));
        end
        for (int k = 0; k < 8; k++) step(0, 0, 2'b00);
        chk("sweep_cnt",  0, ifa.cnt, 8'd5);
        chk("sweep_lost", 0, {7'b0, ifa.lost}, 8'd0);

        // v held high with y=3: back-to-back decodes, lost sets once busy.
        step(1, 0, 2'b00);
        for (int k = 0; k < 20; k++) step(0, 1, 2'b11);
        step(0, 0, 2'b00);
        chk("held_lost", 1, {7'b0, ifb.lost}, 8'd1);

        // v during ACTIVE only: lost persists until reset.
        step(1, 0, 2'b00);
        step(0, 1, 2'b01);
        step(0, 1, 2'b10);
        for (int k = 0; k < 10; k++) step(0, 0, 2'b00);
        chk("lost_sticky", 0, {7'b0, ifa.lost}, 8'd1);

        // Reset during the 2nd ACTIVE cycle aborts the decode without done.
        step(1, 0, 2'b00);
        step(0, 1, 2'b01);
        step(0, 0, 2'b00);
        step(1, 0, 2'b00);
        step(0, 0, 2'b00);
        chk("abort_ready", 0, {7'b0, ifa.ready}, 8'd1);
        step(0, 0, 2'b00);

        // Random traffic with occasional resets.
        for (int k = 0; k < 1500; k++) begin
            step(($urandom_range(0, 199) == 0), ($urandom_range(0, 2) != 0), 2'($urandom_range(0, 3)));
        end

        // Saturation: far more than 255 accepts without reset.
        step(1, 0, 2'b00);
        for (int k = 0; k < 2000; k++) step(0, 1, 2'($urandom_range(0, 3)));
        for (int k = 0; k < 10; k++) step(0, 0, 2'b00);
        chk("sat_cnt", 0, ifa.cnt, 8'd255);
        chk("sat_cnt", 1, ifb.cnt, 8'd255);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
